// File: rtl/fifo_ctrl_sync.sv
// Synchronous FIFO controller: pointer/flag logic driving an external dual-port RAM
// with registered write and combinational (first-word fall-through) read.
module fifo_ctrl_sync #(
  parameter int ASIZE      = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic             rd_valid,
  input  logic             rd_ready,
  input  logic             flush,
  input  logic             err_clr,
  output logic             mem_wen,
  output logic [ASIZE-1:0] mem_waddr,
  output logic [ASIZE-1:0] mem_raddr,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ASIZE:0] AF_LVL = (ASIZE+1)'(AFULL_LVL);
  localparam logic [ASIZE:0] AE_LVL = (ASIZE+1)'(AEMPTY_LVL);

  // Extra MSB on each pointer distinguishes full from empty when low bits match.
  logic [ASIZE:0] wptr, rptr;
  logic           push, pop;

  assign empty        = (wptr == rptr);
  assign full         = (wptr[ASIZE] != rptr[ASIZE]) &&
                        (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
  assign count        = wptr - rptr;
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  assign wr_ready  = ~full;
  assign rd_valid  = ~empty;
  assign mem_waddr = wptr[ASIZE-1:0];
  assign mem_raddr = rptr[ASIZE-1:0];

  assign push    = wr_valid & wr_ready & ~flush;
  assign pop     = rd_valid & rd_ready & ~flush;
  assign mem_wen = push & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Sticky error flags: a new error in the same cycle beats err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_valid & full)  | (overflow  & ~err_clr);
      underflow <= (rd_ready & empty) | (underflow & ~err_clr);
    end
  end

endmodule
